// File: rtl/lc3_fetch_responder.sv
// LC3 fetch stage, responder side of the fetch_in bus: owns the PC, issues single
// outstanding instruction-memory reads, squashes stale reads and flags timeouts.
module lc3_fetch_responder #(
    parameter logic [15:0] RESET_PC       = 16'h3000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_updatePC,
    input  logic        enable_fetch,
    input  logic [15:0] taddr,
    input  logic        br_taken,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic        instrmem_rd,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [15:0] imem_dout,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [7:0]  squash_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  squash_q, squash_d;
    logic [7:0]  timer_q, timer_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= 16'h0000;
            req_q    <= 1'b0;
            instr_q  <= 16'h0000;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            squash_q <= 8'h00;
            timer_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            squash_q <= squash_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = 1'b0;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        squash_d = squash_q;
        timer_d  = timer_q;

        if (enable_updatePC) begin
            pc_d = br_taken ? taddr : pc_q + 16'd1;
        end

        // Reads always latch the PC as it stands before any same-edge update.
        unique case (state_q)
            IDLE: begin
                if (enable_fetch) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    timer_d = 8'h00;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (enable_updatePC && br_taken) begin
                    if (squash_q != 8'hFF) begin
                        squash_d = squash_q + 8'd1;
                    end
                    state_d = IDLE;
                end else if (imem_valid) begin
                    instr_d = imem_dout;
                    valid_d = 1'b1;
                    if (enable_fetch) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        timer_d = 8'h00;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc           = pc_q;
    assign npc          = pc_q + 16'd1;
    assign instrmem_rd  = enable_fetch & reset;
    assign imem_addr    = addr_q;
    assign imem_req     = req_q;
    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;
    assign fetch_err    = err_q;
    assign squash_count = squash_q;

endmodule
